vend_change: RTL

Parametrised successor to the single-price newspaper vending FSM. It accumulates coin credit against a configurable price, asserts a one-cycle vend pulse, and returns any overpayment as serial one-unit change pulses. It also supports a cancel/refund request and flags refused coins. It sits between the coin acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vend_change.sv | 112 +++++++++++
 1 files changed

// File: rtl/vend_change.sv
// Coin-credit vending controller: accumulates credit against PRICE, pulses a vend,
// then pays back any remainder (or a cancelled credit) as one-unit change pulses.
module vend_change #(
  parameter int PRICE     = 3,
  parameter int CREDIT_W  = 4,
  parameter int COIN3_VAL = 5
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [1:0]          coin_i,
  input  logic                cancel_i,
  output logic                newspaper_o,
  output logic                change_pulse_o,
  output logic                coin_reject_o,
  output logic                busy_o,
  output logic [CREDIT_W-1:0] credit_o
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_W = PRICE[CREDIT_W-1:0];
  localparam logic [CREDIT_W-1:0] COIN3_W = COIN3_VAL[CREDIT_W-1:0];
  localparam logic [CREDIT_W-1:0] ONE_W   = {{(CREDIT_W-1){1'b0}}, 1'b1};
  localparam logic [CREDIT_W-1:0] TWO_W   = ONE_W << 1;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                coin_present;

  always_comb begin
    coin_val = '0;
    unique case (coin_i)
      2'b01:   coin_val = ONE_W;
      2'b10:   coin_val = TWO_W;
      2'b11:   coin_val = COIN3_W;
      default: coin_val = '0;
    endcase
  end

  assign coin_present = (coin_i != 2'b00);
  // Design constraints guarantee this sum cannot wrap, so no overflow guard.
  assign sum = credit_q + coin_val;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (cancel_i) begin
          reject_d = coin_present;
          if (credit_q != '0) state_d = CHANGE;
        end else if (coin_present) begin
          if (sum >= PRICE_W) begin
            state_d  = VEND;
            credit_d = sum - PRICE_W;
          end else begin
            credit_d = sum;
          end
        end
      end
      VEND: begin
        reject_d = coin_present;
        state_d  = (credit_q != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        reject_d = coin_present;
        if (credit_q <= ONE_W) begin
          credit_d = '0;
          state_d  = COLLECT;
        end else begin
          credit_d = credit_q - ONE_W;
        end
      end
      default: begin
        state_d  = COLLECT;
        credit_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign newspaper_o    = (state_q == VEND);
  assign change_pulse_o = (state_q == CHANGE);
  assign busy_o         = (state_q != COLLECT);
  assign coin_reject_o  = reject_q;
  assign credit_o       = credit_q;

endmodule
